// File: rtl/mbfifo_pkg.sv
// Shared definitions for the multi-bank FIFO: default sizes, derived widths
// and the accept rules used by every bank. The optional per-master drop
// counters are enabled with the MBFIFO_DROP_CNT_EN macro (see multi_bank_fifo).
package mbfifo_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_BANKS_DEF = 4;
  localparam int DEPTH_DEF     = 8;

  localparam int ID_W  = $clog2(NUM_BANKS_DEF);
  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int CNT_W = PTR_W + 1;

  // A write in a given slot (0 = first writer, 1 = second writer to the same
  // bank) fits only if the start-of-cycle count leaves room for every word
  // ahead of it as well.
  function automatic logic wr_accept(input int cnt, input int depth, input int slot);
    return (cnt + slot) < depth;
  endfunction

  // A read in a given slot needs that many words beyond the ones consumed by
  // earlier slots, again judged on the start-of-cycle count.
  function automatic logic rd_accept(input int cnt, input int slot);
    return cnt > slot;
  endfunction

endpackage

// File: rtl/mbfifo_bank.sv
// One circular bank with two write ports and two read ports. Port 0 always
// belongs to master M0 and has priority; port 1 (M1) is shifted by one slot
// when M0 targets the same bank in the same cycle.
module mbfifo_bank
  import mbfifo_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              rd0_en_i,
  input  logic              rd1_en_i,
  output logic              wr0_ok_o,
  output logic              wr1_ok_o,
  output logic              rd0_ok_o,
  output logic              rd1_ok_o,
  output logic [DATA_W-1:0] rd0_data_o,
  output logic [DATA_W-1:0] rd1_data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr1_slot, rd1_slot;
  logic              full_q, empty_q;
  int                wr1_pos, rd1_pos;

  // Accept decisions, slot addresses and next-state, all from start-of-cycle state
  always_comb begin
    wr1_pos    = wr0_en_i ? 1 : 0;
    rd1_pos    = rd0_en_i ? 1 : 0;
    wr0_ok_o   = wr0_en_i && wr_accept(int'(cnt_q), DEPTH, 0);
    wr1_ok_o   = wr1_en_i && wr_accept(int'(cnt_q), DEPTH, wr1_pos);
    rd0_ok_o   = rd0_en_i && rd_accept(int'(cnt_q), 0);
    rd1_ok_o   = rd1_en_i && rd_accept(int'(cnt_q), rd1_pos);
    wr1_slot   = wr_ptr_q + PTR_W'(wr1_pos);
    rd1_slot   = rd_ptr_q + PTR_W'(rd1_pos);
    rd0_data_o = mem_q[rd_ptr_q];
    rd1_data_o = mem_q[rd1_slot];
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr0_ok_o) + PTR_W'(wr1_ok_o);
    rd_ptr_d   = rd_ptr_q + PTR_W'(rd0_ok_o) + PTR_W'(rd1_ok_o);
    cnt_d      = cnt_q + CNT_W'(wr0_ok_o) + CNT_W'(wr1_ok_o)
                       - CNT_W'(rd0_ok_o) - CNT_W'(rd1_ok_o);
  end

  // Storage: M1's word lands directly behind M0's when both are accepted
  always_ff @(posedge clk) begin
    if (wr0_ok_o) mem_q[wr_ptr_q] <= wr0_data_i;
    if (wr1_ok_o) mem_q[wr1_slot] <= wr1_data_i;
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_W'(DEPTH));
      empty_q  <= (cnt_d == '0);
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/multi_bank_fifo.sv
// Dual-master banked FIFO: NUM_BANKS independent circular banks shared by
// masters M0 and M1. The top decodes bank ids, hands each bank its requests
// and registers read data, valid and write acknowledge per master.
// Optional: MBFIFO_DROP_CNT_EN adds saturating per-master rejected-write counters.
module multi_bank_fifo
  import mbfifo_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  NUM_BANKS = NUM_BANKS_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  localparam int ID_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_M0,
  input  logic [ID_W-1:0]      wr_id_M0,
  input  logic [DATA_W-1:0]    data_in_M0,
  input  logic                 wr_en_M1,
  input  logic [ID_W-1:0]      wr_id_M1,
  input  logic [DATA_W-1:0]    data_in_M1,
  input  logic                 rd_en_M0,
  input  logic [ID_W-1:0]      rd_id_M0,
  input  logic                 rd_en_M1,
  input  logic [ID_W-1:0]      rd_id_M1,
  output logic [DATA_W-1:0]    data_out_M0,
  output logic [DATA_W-1:0]    data_out_M1,
  output logic                 valid_M0,
  output logic                 valid_M1,
  output logic                 wr_ack_M0,
  output logic                 wr_ack_M1,
`ifdef MBFIFO_DROP_CNT_EN
  output logic [7:0]           drop_cnt_M0,
  output logic [7:0]           drop_cnt_M1,
`endif
  output logic [NUM_BANKS-1:0] full,
  output logic [NUM_BANKS-1:0] empty
);

  logic [NUM_BANKS-1:0] b_wr0_ok, b_wr1_ok, b_rd0_ok, b_rd1_ok;
  logic [DATA_W-1:0]    b_rd0_data [NUM_BANKS];
  logic [DATA_W-1:0]    b_rd1_data [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mbfifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr0_en_i   (wr_en_M0 && (wr_id_M0 == ID_W'(b))),
      .wr0_data_i (data_in_M0),
      .wr1_en_i   (wr_en_M1 && (wr_id_M1 == ID_W'(b))),
      .wr1_data_i (data_in_M1),
      .rd0_en_i   (rd_en_M0 && (rd_id_M0 == ID_W'(b))),
      .rd1_en_i   (rd_en_M1 && (rd_id_M1 == ID_W'(b))),
      .wr0_ok_o   (b_wr0_ok[b]),
      .wr1_ok_o   (b_wr1_ok[b]),
      .rd0_ok_o   (b_rd0_ok[b]),
      .rd1_ok_o   (b_rd1_ok[b]),
      .rd0_data_o (b_rd0_data[b]),
      .rd1_data_o (b_rd1_data[b]),
      .full_o     (full[b]),
      .empty_o    (empty[b])
    );
  end

  logic              wr_ok_m0, wr_ok_m1, rd_ok_m0, rd_ok_m1;
  logic [DATA_W-1:0] dout_m0_q, dout_m0_d, dout_m1_q, dout_m1_d;
  logic              valid_m0_q, valid_m1_q, ack_m0_q, ack_m1_q;

  // Only the addressed bank can accept, so OR-reduction gives the per-master result
  always_comb begin
    wr_ok_m0  = |b_wr0_ok;
    wr_ok_m1  = |b_wr1_ok;
    rd_ok_m0  = |b_rd0_ok;
    rd_ok_m1  = |b_rd1_ok;
    dout_m0_d = rd_ok_m0 ? b_rd0_data[rd_id_M0] : dout_m0_q;
    dout_m1_d = rd_ok_m1 ? b_rd1_data[rd_id_M1] : dout_m1_q;
  end

  // Registered read data (held on rejected reads), valid pulse and write ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_m0_q  <= '0;
      dout_m1_q  <= '0;
      valid_m0_q <= 1'b0;
      valid_m1_q <= 1'b0;
      ack_m0_q   <= 1'b0;
      ack_m1_q   <= 1'b0;
    end else begin
      dout_m0_q  <= dout_m0_d;
      dout_m1_q  <= dout_m1_d;
      valid_m0_q <= rd_ok_m0;
      valid_m1_q <= rd_ok_m1;
      ack_m0_q   <= wr_ok_m0;
      ack_m1_q   <= wr_ok_m1;
    end
  end

  assign data_out_M0 = dout_m0_q;
  assign data_out_M1 = dout_m1_q;
  assign valid_M0    = valid_m0_q;
  assign valid_M1    = valid_m1_q;
  assign wr_ack_M0   = ack_m0_q;
  assign wr_ack_M1   = ack_m1_q;

`ifdef MBFIFO_DROP_CNT_EN
  logic [7:0] drop_m0_q, drop_m1_q;

  // Count rejected writes per master, sticking at 255
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_m0_q <= '0;
      drop_m1_q <= '0;
    end else begin
      if (wr_en_M0 && !wr_ok_m0 && drop_m0_q != 8'hFF) drop_m0_q <= drop_m0_q + 8'd1;
      if (wr_en_M1 && !wr_ok_m1 && drop_m1_q != 8'hFF) drop_m1_q <= drop_m1_q + 8'd1;
    end
  end

  assign drop_cnt_M0 = drop_m0_q;
  assign drop_cnt_M1 = drop_m1_q;
`endif

endmodule

// File: tb/tb_multi_bank_fifo.sv
// Self-checking bench for multi_bank_fifo with default sizes (8-bit data,
// 4 banks, depth 8). A queue-per-bank reference model predicts every output
// one clock after the inputs are applied.
module tb_multi_bank_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en_M0, wr_en_M1, rd_en_M0, rd_en_M1;
  logic [1:0] wr_id_M0, wr_id_M1, rd_id_M0, rd_id_M1;
  logic [7:0] data_in_M0, data_in_M1;
  logic [7:0] data_out_M0, data_out_M1;
  logic       valid_M0, valid_M1, wr_ack_M0, wr_ack_M1;
  logic [3:0] full, empty;
`ifdef MBFIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_M0, drop_cnt_M1;
  int         e_drop0 = 0, e_drop1 = 0;
`endif

  always #5 clk = ~clk;

  multi_bank_fifo dut (
    .clk(clk), .rst(rst),
    .wr_en_M0(wr_en_M0), .wr_id_M0(wr_id_M0), .data_in_M0(data_in_M0),
    .wr_en_M1(wr_en_M1), .wr_id_M1(wr_id_M1), .data_in_M1(data_in_M1),
    .rd_en_M0(rd_en_M0), .rd_id_M0(rd_id_M0),
    .rd_en_M1(rd_en_M1), .rd_id_M1(rd_id_M1),
    .data_out_M0(data_out_M0), .data_out_M1(data_out_M1),
    .valid_M0(valid_M0), .valid_M1(valid_M1),
    .wr_ack_M0(wr_ack_M0), .wr_ack_M1(wr_ack_M1),
`ifdef MBFIFO_DROP_CNT_EN
    .drop_cnt_M0(drop_cnt_M0), .drop_cnt_M1(drop_cnt_M1),
`endif
    .full(full), .empty(empty)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per bank plus expected registered outputs
  logic [7:0] mq [4][$];
  logic [7:0] e_d0 = 8'h00, e_d1 = 8'h00;
  logic       e_v0 = 1'b0, e_v1 = 1'b0, e_a0 = 1'b0, e_a1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] ef, ee;
    for (int b = 0; b < 4; b++) begin
      ef[b] = (mq[b].size() == 8);
      ee[b] = (mq[b].size() == 0);
    end
    chk("valid_M0", 32'(valid_M0), 32'(e_v0));
    chk("valid_M1", 32'(valid_M1), 32'(e_v1));
    chk("data_out_M0", 32'(data_out_M0), 32'(e_d0));
    chk("data_out_M1", 32'(data_out_M1), 32'(e_d1));
    chk("wr_ack_M0", 32'(wr_ack_M0), 32'(e_a0));
    chk("wr_ack_M1", 32'(wr_ack_M1), 32'(e_a1));
    chk("full", 32'(full), 32'(ef));
    chk("empty", 32'(empty), 32'(ee));
`ifdef MBFIFO_DROP_CNT_EN
    chk("drop_cnt_M0", 32'(drop_cnt_M0), 32'(e_drop0));
    chk("drop_cnt_M1", 32'(drop_cnt_M1), 32'(e_drop1));
`endif
  endtask

  // Apply current inputs for one clock, advance the model, check outputs
  task automatic cyc();
    int         sz [4];
    int         p1;
    logic       a0, a1, r0, r1;
    logic [7:0] d0, d1;
    for (int b = 0; b < 4; b++) sz[b] = mq[b].size();
    a0 = 1'b0; a1 = 1'b0; r0 = 1'b0; r1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    if (rst) begin
      a0 = wr_en_M0 && (sz[wr_id_M0] < 8);
      a1 = wr_en_M1 && (sz[wr_id_M1] + ((wr_en_M0 && wr_id_M0 == wr_id_M1) ? 1 : 0) < 8);
      p1 = (rd_en_M0 && rd_id_M0 == rd_id_M1) ? 1 : 0;
      r0 = rd_en_M0 && (sz[rd_id_M0] > 0);
      r1 = rd_en_M1 && (sz[rd_id_M1] > p1);
      if (r0) d0 = mq[rd_id_M0][0];
      if (r1) d1 = mq[rd_id_M1][p1];
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int b = 0; b < 4; b++) mq[b].delete();
      e_d0 = 8'h00; e_d1 = 8'h00;
      e_v0 = 1'b0; e_v1 = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0;
`ifdef MBFIFO_DROP_CNT_EN
      e_drop0 = 0; e_drop1 = 0;
`endif
    end else begin
      if (r0) void'(mq[rd_id_M0].pop_front());
      if (r1) void'(mq[rd_id_M1].pop_front());
      if (a0) mq[wr_id_M0].push_back(data_in_M0);
      if (a1) mq[wr_id_M1].push_back(data_in_M1);
      e_v0 = r0; e_v1 = r1; e_a0 = a0; e_a1 = a1;
      if (r0) e_d0 = d0;
      if (r1) e_d1 = d1;
`ifdef MBFIFO_DROP_CNT_EN
      if (wr_en_M0 && !a0 && e_drop0 < 255) e_drop0++;
      if (wr_en_M1 && !a1 && e_drop1 < 255) e_drop1++;
`endif
    end
    check_all();
  endtask

  // Drive one cycle of requests; disabled ids/data are randomised on purpose
  task automatic op(input logic we0, input logic [1:0] wi0, input logic [7:0] wd0,
                    input logic we1, input logic [1:0] wi1, input logic [7:0] wd1,
                    input logic re0, input logic [1:0] ri0,
                    input logic re1, input logic [1:0] ri1);
    wr_en_M0 = we0; wr_id_M0 = we0 ? wi0 : 2'($urandom); data_in_M0 = we0 ? wd0 : 8'($urandom);
    wr_en_M1 = we1; wr_id_M1 = we1 ? wi1 : 2'($urandom); data_in_M1 = we1 ? wd1 : 8'($urandom);
    rd_en_M0 = re0; rd_id_M0 = re0 ? ri0 : 2'($urandom);
    rd_en_M1 = re1; rd_id_M1 = re1 ? ri1 : 2'($urandom);
    cyc();
  endtask

  task automatic rand_inputs();
    wr_en_M0 = 1'($urandom); wr_id_M0 = 2'($urandom); data_in_M0 = 8'($urandom);
    wr_en_M1 = 1'($urandom); wr_id_M1 = 2'($urandom); data_in_M1 = 8'($urandom);
    rd_en_M0 = 1'($urandom); rd_id_M0 = 2'($urandom);
    rd_en_M1 = 1'($urandom); rd_id_M1 = 2'($urandom);
  endtask

  initial begin
    // Reset held two cycles with random requests
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      cyc();
    end
    rst = 1'b1;
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // M0 fills bank 2 in order, M1 drains it
    for (int i = 0; i < 8; i++) op(1, 2, 8'(8'h10 + i), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) op(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill bank 1, overflow attempt, drain; twice to wrap pointers
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) op(1, 1, 8'($urandom), 0, 0, 0, 0, 0, 0, 0);
      op(1, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) op(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      op(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    end

    // Dual write then dual read of bank 3
    op(1, 3, 8'h01, 1, 3, 8'h02, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 1, 3, 1, 3);

    // Single word, dual read: only M0 served
    op(1, 0, 8'h5A, 0, 0, 0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    // Seven words then dual write: M0 fills last slot, M1 rejected
    for (int i = 0; i < 7; i++) op(1, 0, 8'(8'h30 + i), 0, 0, 0, 0, 0, 0, 0);
    op(1, 0, 8'hC0, 1, 0, 8'hC1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) op(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

    // Read of an empty bank concurrent with a write to it
    op(1, 2, 8'h77, 0, 0, 0, 0, 0, 1, 2);
    op(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

    // Mid-traffic reset
    for (int i = 0; i < 10; i++) op(1, 1, 8'($urandom), 1, 2, 8'($urandom), 0, 0, 0, 0);
    rst = 1'b0;
    rand_inputs();
    cyc();
    rst = 1'b1;
    op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
